green_frame_sequencer: RTL
==========================

# green_frame_sequencer

Camera-side controller for the green-pixel detector. It de-interleaves the OV7670 YCbCr 4:2:2 byte stream into per-pixel Y/Cb/Cr words and issues one `e_pix` strobe per pixel to the detector. It collects the detector's `verde` flag back with pixel coordinates and publishes a per-frame green count, bounding box and found flag at each frame end. It sits between the camera capture pins and the tracking/sprite logic.

## Interface
- `H_ACTIVE`, 640: pixels per line; extra pixels are ignored.
- `V_ACTIVE`, 480: lines per frame; extra lines are ignored.
- `MIN_PIXELS`, 64: minimum green count for `found` = 1.
- `PCLK`  in  1  pixel clock; all logic on the rising edge. One clock; reset is asynchronous and active-low.
- `reset_n`  in  1  asynchronous active-low reset.
- `VSYNC`  in  1  high = vertical blanking.
- `HREF`  in  1  high = active line bytes on `D`.
- `D`  in  8  camera byte bus.
- `Y`  out  8  luma word to the detector.
- `Cb`  out  8  Cb word to the detector.
- `Cr`  out  8  Cr word to the detector.
- `e_pix`  out  1  one-cycle pixel strobe to the detector.
- `verde`  in  1  detector result for the `e_pix` of the previous cycle.
- `green_count`  out  19  green pixels in the last completed frame.
- `x_min`, `x_max`  out  10 each  bounding box columns.
- `y_min`, `y_max`  out  9 each  bounding box rows.
- `found`  out  1  `green_count` >= `MIN_PIXELS`.
- `frame_done`  out  1  one-cycle pulse when results update.

## Operation
- FSM states: IDLE, ACTIVE, FLUSH, PUBLISH.
- IDLE: waits for a falling edge of `VSYNC`, detected from a registered copy of `VSYNC`. On the edge, clears the accumulators and goes to ACTIVE.
- ACTIVE: a 2-bit byte phase advances on each cycle with `HREF` = 1. Byte order is 0 = Cb, 1 = Y0, 2 = Cr, 3 = Y1.
  - Phase 2 edge: drive `Y` <= Y0, `Cb` <= Cb, `Cr` <= `D`, `e_pix` <= 1.
  - Phase 3 edge: drive `Y` <= `D`, `e_pix` <= 1; `Cb`/`Cr` hold.
  - All other edges: `e_pix` <= 0.
- Column counter `x` increments after each `e_pix`. A one-stage copy `x_d` and `y_d` pairs with `verde` in the following cycle.
- On `verde` = 1 with `x_d` < `H_ACTIVE` and `y_d` < `V_ACTIVE`:
  - `green_count` accumulator +1, saturating at 2^19-1.
  - Update the running min/max of x and y.
- `HREF` falling edge:
  - Phase resets to 0; a partial pixel pair is discarded with no `e_pix`.
  - `x` resets to 0.
  - `y` increments only if the line produced at least one `e_pix`.
- `VSYNC` rising edge in ACTIVE: go to FLUSH, even if `HREF` is still high. No new `e_pix` is issued after this edge.
- FLUSH: lasts one cycle, so the final `verde` is still accumulated. Then go to PUBLISH.
- PUBLISH: lasts one cycle.
  - Copy the accumulators to the outputs; pulse `frame_done` = 1.
  - If the count is 0, all box outputs are 0 and `found` = 0.
  - Return to IDLE.
- Initial box accumulator values: min = all-ones, max = 0.

## Timing
- Reset values: state IDLE, phase 0, `e_pix` 0, `Y`/`Cb`/`Cr` 0, all result outputs 0, `frame_done` 0, `x`/`y` 0.
- Reset mid-frame: the partial frame is discarded; the block waits for the next `VSYNC` fall.
- The first frame after reset is processed only if `VSYNC` falls after `reset_n` deasserts.
- Latency:
  - Cr byte to Y0 `e_pix`: 1 cycle.
  - Y1 byte to Y1 `e_pix`: 1 cycle.
  - `e_pix` to `verde` sampled: 1 cycle.
- `e_pix` pattern within a line: 0,0,1,1 repeating, two strobes per 4 bytes. Words are stable for the whole strobe cycle.
- `frame_done` is asserted 2 cycles after the `VSYNC` rise is detected. Results hold until the next `frame_done`.
- `VSYNC` fall while in FLUSH or PUBLISH is ignored; that frame is skipped.

## Test plan
- One line of 4 pixels: bytes Cb=0x80, Y0=0x40, Cr=0x90, Y1=0x50, then Cb=0x70, Y0=0x60, Cr=0x88, Y1=0x70 -> `e_pix` on the cycles after bytes 2, 3, 6 and 7. Words are (0x40,0x80,0x90), (0x50,0x80,0x90), (0x60,0x70,0x88), (0x70,0x70,0x88).
- 8x4 frame, `verde` forced high for pixels (2..5, 1..2), `MIN_PIXELS`=4 -> `green_count`=8, x 2..5, y 1..2, `found`=1, one `frame_done` pulse.
- Same frame with `verde` never high -> count 0, all box outputs 0, `found`=0.
- `HREF` drops after byte 1 of a pair -> no `e_pix` for that pair. The next line starts at x=0 with `y` +1.
- `VSYNC` rises one cycle after the last `e_pix` with `verde`=1 -> that pixel is included in the count.
- `reset_n` pulsed mid-frame -> outputs 0 immediately. No `frame_done` until a full `VSYNC` fall/rise cycle has completed.

Source files
------------

// File: rtl/green_frame_sequencer.sv
// Camera-side sequencer for the green detector: splits the YCbCr 4:2:2 byte stream into
// per-pixel strobes and folds the detector's verdicts into per-frame count and bounding box.
module green_frame_sequencer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MIN_PIXELS = 64
) (
    input  logic        PCLK,
    input  logic        reset_n,
    input  logic        VSYNC,
    input  logic        HREF,
    input  logic [7:0]  D,
    output logic [7:0]  Y,
    output logic [7:0]  Cb,
    output logic [7:0]  Cr,
    output logic        e_pix,
    input  logic        verde,
    output logic [18:0] green_count,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [8:0]  y_min,
    output logic [8:0]  y_max,
    output logic        found,
    output logic        frame_done
);

    localparam logic [9:0]  H_LIM   = 10'(H_ACTIVE);
    localparam logic [8:0]  V_LIM   = 9'(V_ACTIVE);
    localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, PUBLISH} state_t;

    typedef struct packed {
        logic [18:0] cnt;
        logic [9:0]  x_lo;
        logic [9:0]  x_hi;
        logic [8:0]  y_lo;
        logic [8:0]  y_hi;
    } stats_t;

    localparam stats_t STATS_CLR = {19'd0, 10'h3ff, 10'd0, 9'h1ff, 9'd0};

    state_t      state;
    stats_t      acc;
    logic        vsync_q;
    logic        href_q;
    logic [1:0]  phase;
    logic [7:0]  cb_q;
    logic [7:0]  y0_q;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [9:0]  x_d;
    logic [8:0]  y_d;
    logic        line_pix;
    // [0] is the pixel strobe itself, [1] marks the cycle its verdict arrives
    logic [1:0]  vld_pipe;

    logic        vs_fall;
    logic        vs_rise;
    logic        hit;

    assign e_pix   = vld_pipe[0];
    assign vs_fall = vsync_q & ~VSYNC;
    assign vs_rise = ~vsync_q & VSYNC;
    assign hit     = vld_pipe[1] & verde & (x_d < H_LIM) & (y_d < V_LIM);

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            acc         <= STATS_CLR;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            phase       <= 2'd0;
            cb_q        <= 8'd0;
            y0_q        <= 8'd0;
            x           <= 10'd0;
            y           <= 9'd0;
            x_d         <= 10'd0;
            y_d         <= 9'd0;
            line_pix    <= 1'b0;
            vld_pipe    <= 2'b00;
            Y           <= 8'd0;
            Cb          <= 8'd0;
            Cr          <= 8'd0;
            green_count <= 19'd0;
            x_min       <= 10'd0;
            x_max       <= 10'd0;
            y_min       <= 9'd0;
            y_max       <= 9'd0;
            found       <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            vsync_q    <= VSYNC;
            href_q     <= HREF;
            frame_done <= 1'b0;
            vld_pipe   <= {vld_pipe[0], 1'b0};
            x_d        <= x;
            y_d        <= y;

            // FLUSH still accumulates so the verdict for the final strobe is not lost
            if ((state == ACTIVE || state == FLUSH) && hit) begin
                if (acc.cnt != '1)
                    acc.cnt <= acc.cnt + 1'b1;
                if (x_d < acc.x_lo) acc.x_lo <= x_d;
                if (x_d > acc.x_hi) acc.x_hi <= x_d;
                if (y_d < acc.y_lo) acc.y_lo <= y_d;
                if (y_d > acc.y_hi) acc.y_hi <= y_d;
            end

            case (state)
                IDLE: begin
                    if (vs_fall) begin
                        acc      <= STATS_CLR;
                        phase    <= 2'd0;
                        x        <= 10'd0;
                        y        <= 9'd0;
                        line_pix <= 1'b0;
                        state    <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (vld_pipe[0] && x != H_LIM)
                        x <= x + 1'b1;
                    if (vs_rise) begin
                        state <= FLUSH;
                    end else if (HREF) begin
                        phase <= phase + 1'b1;
                        case (phase)
                            2'd0: cb_q <= D;
                            2'd1: y0_q <= D;
                            2'd2: begin
                                Y           <= y0_q;
                                Cb          <= cb_q;
                                Cr          <= D;
                                vld_pipe[0] <= 1'b1;
                                line_pix    <= 1'b1;
                            end
                            default: begin
                                Y           <= D;
                                vld_pipe[0] <= 1'b1;
                            end
                        endcase
                    end else if (href_q) begin
                        // end of line: an unfinished pair is dropped
                        phase    <= 2'd0;
                        x        <= 10'd0;
                        line_pix <= 1'b0;
                        if (line_pix && y != V_LIM)
                            y <= y + 1'b1;
                    end
                end

                FLUSH: state <= PUBLISH;

                default: begin
                    green_count <= acc.cnt;
                    if (acc.cnt == 19'd0) begin
                        x_min <= 10'd0;
                        x_max <= 10'd0;
                        y_min <= 9'd0;
                        y_max <= 9'd0;
                        found <= 1'b0;
                    end else begin
                        x_min <= acc.x_lo;
                        x_max <= acc.x_hi;
                        y_min <= acc.y_lo;
                        y_max <= acc.y_hi;
                        found <= (acc.cnt >= MIN_CNT);
                    end
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
